// File: rtl/axi_isolate_ctrl.sv
// Connect/isolate controller for one AXI link. All channels pass through combinationally;
// only AW/AR valid/ready are gated, so accepted bursts always drain before isolation is reported.

typedef struct packed {
  logic [3:0]  id;
  logic [31:0] addr;
  logic [7:0]  len;
  logic [2:0]  size;
  logic [1:0]  burst;
} axi_iso_ax_t;

typedef struct packed {
  logic [31:0] data;
  logic [3:0]  strb;
  logic        last;
} axi_iso_w_t;

typedef struct packed {
  logic [3:0] id;
  logic [1:0] resp;
} axi_iso_b_t;

typedef struct packed {
  logic [3:0]  id;
  logic [31:0] data;
  logic [1:0]  resp;
  logic        last;
} axi_iso_r_t;

typedef struct packed {
  axi_iso_ax_t aw;
  logic        aw_valid;
  axi_iso_w_t  w;
  logic        w_valid;
  logic        b_ready;
  axi_iso_ax_t ar;
  logic        ar_valid;
  logic        r_ready;
} axi_iso_req_t;

typedef struct packed {
  logic       aw_ready;
  logic       ar_ready;
  logic       w_ready;
  axi_iso_b_t b;
  logic       b_valid;
  axi_iso_r_t r;
  logic       r_valid;
} axi_iso_resp_t;

module axi_isolate_ctrl #(
  parameter int unsigned MaxTxn = 8,
  parameter type axi_req_t  = axi_iso_req_t,
  parameter type axi_resp_t = axi_iso_resp_t
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      isolate_i,
  output logic      isolated_o,
  output logic      busy_o,
  input  axi_req_t  slv_req_i,
  output axi_resp_t slv_resp_o,
  output axi_req_t  mst_req_o,
  input  axi_resp_t mst_resp_i
);

  localparam int unsigned CntW = $clog2(MaxTxn + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MaxTxn);

  typedef enum logic [1:0] {CONNECTED, DRAIN, ISOLATED} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic            aw_pend_q, aw_pend_d, ar_pend_q, ar_pend_d;
  logic            busy_q;
  logic            aw_open, ar_open;
  logic            aw_hs, ar_hs, b_hs, r_last_hs;

  function automatic logic [CntW-1:0] cnt_next(input logic [CntW-1:0] cnt,
                                               input logic inc, input logic dec);
    logic [CntW-1:0] res;
    res = cnt;
    if (inc && !dec)
      res = cnt + CntW'(1);
    else if (dec && !inc && cnt != '0)
      res = cnt - CntW'(1);
    return res;
  endfunction

  // Payloads pass untouched; only the address-channel handshake is gated.
  always_comb begin
    mst_req_o           = slv_req_i;
    mst_req_o.aw_valid  = slv_req_i.aw_valid & aw_open;
    mst_req_o.ar_valid  = slv_req_i.ar_valid & ar_open;
    slv_resp_o          = mst_resp_i;
    slv_resp_o.aw_ready = mst_resp_i.aw_ready & aw_open;
    slv_resp_o.ar_ready = mst_resp_i.ar_ready & ar_open;
  end

  assign aw_hs     = mst_req_o.aw_valid & mst_resp_i.aw_ready;
  assign ar_hs     = mst_req_o.ar_valid & mst_resp_i.ar_ready;
  assign b_hs      = mst_resp_i.b_valid & slv_req_i.b_ready;
  assign r_last_hs = mst_resp_i.r_valid & slv_req_i.r_ready & mst_resp_i.r.last;

  always_comb begin
    wr_cnt_d  = cnt_next(wr_cnt_q, aw_hs, b_hs);
    rd_cnt_d  = cnt_next(rd_cnt_q, ar_hs, r_last_hs);
    // A presented-but-unaccepted address stays open until it completes.
    aw_pend_d = mst_req_o.aw_valid & ~mst_resp_i.aw_ready;
    ar_pend_d = mst_req_o.ar_valid & ~mst_resp_i.ar_ready;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= CONNECTED;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      aw_pend_q <= 1'b0;
      ar_pend_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      aw_pend_q <= aw_pend_d;
      ar_pend_q <= ar_pend_d;
      busy_q    <= (wr_cnt_d != '0) | (rd_cnt_d != '0);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      CONNECTED: if (isolate_i) state_d = DRAIN;
      DRAIN: begin
        if (!isolate_i)
          state_d = CONNECTED;
        else if (wr_cnt_d == '0 && rd_cnt_d == '0 && !aw_pend_d && !ar_pend_d)
          state_d = ISOLATED;
      end
      ISOLATED:  if (!isolate_i) state_d = CONNECTED;
      default:   state_d = CONNECTED;
    endcase
  end

  always_comb begin
    aw_open    = ((state_q == CONNECTED) && (wr_cnt_q < CntMax)) || aw_pend_q;
    ar_open    = ((state_q == CONNECTED) && (rd_cnt_q < CntMax)) || ar_pend_q;
    isolated_o = (state_q == ISOLATED);
    busy_o     = busy_q;
  end

  wr_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(b_hs && !aw_hs && wr_cnt_q == '0));
  rd_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(r_last_hs && !ar_hs && rd_cnt_q == '0));
  wr_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(aw_hs && !b_hs && wr_cnt_q == CntMax));
  rd_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(ar_hs && !r_last_hs && rd_cnt_q == CntMax));

endmodule

// File: tb/tb_axi_isolate_ctrl.sv
// Bench for axi_isolate_ctrl: acts as both upstream manager and downstream subordinate,
// with a scoreboard on every forwarded handshake plus direct checks of gating and status.

module tb_axi_isolate_ctrl;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } tb_ax_t;
  typedef struct packed { logic [31:0] data; logic [3:0] strb; logic last; } tb_w_t;
  typedef struct packed { logic [3:0] id; logic [1:0] resp; } tb_b_t;
  typedef struct packed { logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last; } tb_r_t;
  typedef struct packed {
    tb_ax_t aw; logic aw_valid; tb_w_t w; logic w_valid; logic b_ready;
    tb_ax_t ar; logic ar_valid; logic r_ready;
  } tb_req_t;
  typedef struct packed {
    logic aw_ready; logic ar_ready; logic w_ready; tb_b_t b; logic b_valid;
    tb_r_t r; logic r_valid;
  } tb_resp_t;

  localparam int unsigned AW = 0, WC = 1, AR = 2, BC = 3, RC = 4;

  logic     clk_i = 1'b0;
  logic     rst_ni = 1'b0;
  logic     isolate;
  logic     isolated_o, busy_o;
  tb_req_t  slv_req, mst_req;
  tb_resp_t slv_resp, mst_resp;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [63:0] aw_exp[$], w_exp[$], ar_exp[$], b_exp[$], r_exp[$];

  axi_isolate_ctrl #(
    .MaxTxn    (2),
    .axi_req_t (tb_req_t),
    .axi_resp_t(tb_resp_t)
  ) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .isolate_i (isolate),
    .isolated_o(isolated_o),
    .busy_o    (busy_o),
    .slv_req_i (slv_req),
    .slv_resp_o(slv_resp),
    .mst_req_o (mst_req),
    .mst_resp_i(mst_resp)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic tb_ax_t mk_ax(input logic [3:0] id, input logic [31:0] addr,
                                   input logic [7:0] len);
    tb_ax_t a;
    a.id = id; a.addr = addr; a.len = len; a.size = 3'd2; a.burst = 2'b01;
    return a;
  endfunction

  // Wait (bounded) for the upstream-visible handshake on a channel; returns just after its edge.
  task automatic wait_hs(input int unsigned ch, input string tag);
    bit seen = 1'b0;
    for (int unsigned i = 0; i < 20 && !seen; i++) begin
      @(negedge clk_i);
      case (ch)
        AW:      seen = slv_req.aw_valid & slv_resp.aw_ready;
        WC:      seen = slv_req.w_valid  & slv_resp.w_ready;
        AR:      seen = slv_req.ar_valid & slv_resp.ar_ready;
        BC:      seen = slv_resp.b_valid & slv_req.b_ready;
        default: seen = slv_resp.r_valid & slv_req.r_ready;
      endcase
      tick();
    end
    if (!seen) check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic wait_iso(input int unsigned max_cyc, input string tag);
    bit seen = 1'b0;
    for (int unsigned i = 0; i < max_cyc && !seen; i++) begin
      @(negedge clk_i);
      seen = isolated_o;
      if (!seen) tick();
    end
    check(tag, seen, 1);
  endtask

  task automatic send_b(input logic [3:0] id, input logic [1:0] resp, input string tag);
    mst_resp.b.id = id; mst_resp.b.resp = resp; mst_resp.b_valid = 1'b1;
    b_exp.push_back({58'h0, id, resp});
    wait_hs(BC, tag);
    mst_resp.b_valid = 1'b0;
  endtask

  task automatic send_r(input logic [31:0] data, input logic last, input string tag);
    mst_resp.r.id = 4'h1; mst_resp.r.data = data; mst_resp.r.resp = 2'b00;
    mst_resp.r.last = last; mst_resp.r_valid = 1'b1;
    r_exp.push_back({31'h0, data, last});
    wait_hs(RC, tag);
    mst_resp.r_valid = 1'b0;
  endtask

  // Scoreboard: every handshake that crosses the DUT must match the next queued item.
  always @(negedge clk_i) if (rst_ni) begin
    if (mst_req.aw_valid && mst_resp.aw_ready) begin
      if (aw_exp.size() == 0) check("aw_unexpected", 1, 0);
      else check("aw_fwd", {24'h0, mst_req.aw.addr, mst_req.aw.len}, aw_exp.pop_front());
    end
    if (mst_req.w_valid && mst_resp.w_ready) begin
      if (w_exp.size() == 0) check("w_unexpected", 1, 0);
      else check("w_fwd", {27'h0, mst_req.w.data, mst_req.w.strb, mst_req.w.last}, w_exp.pop_front());
    end
    if (mst_req.ar_valid && mst_resp.ar_ready) begin
      if (ar_exp.size() == 0) check("ar_unexpected", 1, 0);
      else check("ar_fwd", {24'h0, mst_req.ar.addr, mst_req.ar.len}, ar_exp.pop_front());
    end
    if (slv_resp.b_valid && slv_req.b_ready) begin
      if (b_exp.size() == 0) check("b_unexpected", 1, 0);
      else check("b_fwd", {58'h0, slv_resp.b.id, slv_resp.b.resp}, b_exp.pop_front());
    end
    if (slv_resp.r_valid && slv_req.r_ready) begin
      if (r_exp.size() == 0) check("r_unexpected", 1, 0);
      else check("r_fwd", {31'h0, slv_resp.r.data, slv_resp.r.last}, r_exp.pop_front());
    end
  end

  task automatic reset_checks(input string tag);
    mst_resp.aw_ready = 1'b1; mst_resp.ar_ready = 1'b1;
    @(negedge clk_i);
    check({tag, "_iso"}, isolated_o, 0);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_aw_open"}, slv_resp.aw_ready, 1);
    check({tag, "_ar_open"}, slv_resp.ar_ready, 1);
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    slv_req = '0; mst_resp = '0; isolate = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    reset_checks("reset");
    mst_resp.w_ready = 1'b1; slv_req.b_ready = 1'b1; slv_req.r_ready = 1'b1;

    // Plain forwarding while connected.
    for (int unsigned i = 0; i < 4; i++) begin
      slv_req.aw = mk_ax(4'(i), 32'h1000 + 32'(i * 4), 8'd0); slv_req.aw_valid = 1'b1;
      aw_exp.push_back({24'h0, slv_req.aw.addr, 8'd0});
      slv_req.w.data = 32'hA0 + 32'(i); slv_req.w.strb = 4'hF; slv_req.w.last = 1'b1;
      slv_req.w_valid = 1'b1;
      w_exp.push_back({27'h0, slv_req.w.data, 4'hF, 1'b1});
      wait_hs(AW, "s1_aw");
      slv_req.aw_valid = 1'b0; slv_req.w_valid = 1'b0;
      @(negedge clk_i);
      check("s1_busy", busy_o, 1);
      check("s1_iso", isolated_o, 0);
      tick();
      send_b(4'(i), 2'(i), "s1_b");
    end
    for (int unsigned i = 0; i < 4; i++) begin
      slv_req.ar = mk_ax(4'(i), 32'h2000 + 32'(i * 8), 8'd0); slv_req.ar_valid = 1'b1;
      ar_exp.push_back({24'h0, slv_req.ar.addr, 8'd0});
      wait_hs(AR, "s1_ar");
      slv_req.ar_valid = 1'b0;
      send_r(32'hD0 + 32'(i), 1'b1, "s1_r");
    end
    @(negedge clk_i);
    check("s1_busy_end", busy_o, 0);
    check("s1_iso_end", isolated_o, 0);
    tick();

    // Read limit: third AR stalls until the first read completes.
    for (int unsigned k = 0; k < 2; k++) begin
      slv_req.ar = mk_ax(4'(k), 32'h9000 + 32'(k * 16), 8'd0); slv_req.ar_valid = 1'b1;
      ar_exp.push_back({24'h0, slv_req.ar.addr, 8'd0});
      wait_hs(AR, "s3_ar");
    end
    slv_req.ar = mk_ax(4'h2, 32'h9020, 8'd1);
    ar_exp.push_back({24'h0, 32'h9020, 8'd1});
    repeat (2) begin
      @(negedge clk_i);
      check("s3_stall", slv_resp.ar_ready, 0);
      check("s3_mvalid", mst_req.ar_valid, 0);
      tick();
    end
    mst_resp.r.data = 32'hE000; mst_resp.r.last = 1'b1; mst_resp.r_valid = 1'b1;
    r_exp.push_back({31'h0, 32'hE000, 1'b1});
    @(negedge clk_i);
    check("s3_same_cycle", slv_resp.ar_ready, 0);
    tick();
    mst_resp.r_valid = 1'b0;
    @(negedge clk_i);
    check("s3_resume", slv_resp.ar_ready, 1);
    tick();
    slv_req.ar_valid = 1'b0;
    send_r(32'hE001, 1'b1, "s3_r1");
    send_r(32'hE002, 1'b0, "s3_r2a");
    @(negedge clk_i);
    check("s3_busy_mid", busy_o, 1);
    tick();
    send_r(32'hE003, 1'b1, "s3_r2b");
    @(negedge clk_i);
    check("s3_busy_end", busy_o, 0);
    tick();

    // Simultaneous AW and B handshakes leave the write count unchanged.
    slv_req.aw = mk_ax(4'h6, 32'h6000, 8'd0); slv_req.aw_valid = 1'b1;
    aw_exp.push_back({24'h0, 32'h6000, 8'd0});
    slv_req.w.data = 32'h600; slv_req.w.last = 1'b1; slv_req.w_valid = 1'b1;
    w_exp.push_back({27'h0, 32'h600, 4'hF, 1'b1});
    wait_hs(AW, "s6_aw0");
    slv_req.aw = mk_ax(4'h7, 32'h6100, 8'd0);
    aw_exp.push_back({24'h0, 32'h6100, 8'd0});
    slv_req.w.data = 32'h601;
    w_exp.push_back({27'h0, 32'h601, 4'hF, 1'b1});
    mst_resp.b.id = 4'h6; mst_resp.b.resp = 2'b10; mst_resp.b_valid = 1'b1;
    b_exp.push_back({58'h0, 4'h6, 2'b10});
    @(negedge clk_i);
    check("s6_aw_rdy", slv_resp.aw_ready, 1);
    tick();
    slv_req.aw_valid = 1'b0; slv_req.w_valid = 1'b0; mst_resp.b_valid = 1'b0;
    @(negedge clk_i);
    check("s6_cnt_one", busy_o, 1);
    tick();
    send_b(4'h7, 2'b00, "s6_b");
    @(negedge clk_i);
    check("s6_cnt_zero", busy_o, 0);
    tick();

    // Isolate during a write burst; new AR is held until reconnect.
    slv_req.aw = mk_ax(4'h2, 32'h3000, 8'd7); slv_req.aw_valid = 1'b1;
    aw_exp.push_back({24'h0, 32'h3000, 8'd7});
    wait_hs(AW, "s2_aw");
    slv_req.aw_valid = 1'b0;
    for (int unsigned b = 0; b < 8; b++) begin
      slv_req.w.data = 32'h5000 + 32'(b); slv_req.w.last = (b == 7); slv_req.w_valid = 1'b1;
      w_exp.push_back({27'h0, slv_req.w.data, 4'hF, slv_req.w.last});
      if (b == 2) isolate = 1'b1;
      if (b == 3) begin
        slv_req.ar = mk_ax(4'h5, 32'h7000, 8'd0); slv_req.ar_valid = 1'b1;
        ar_exp.push_back({24'h0, 32'h7000, 8'd0});
      end
      wait_hs(WC, "s2_w");
    end
    slv_req.w_valid = 1'b0;
    repeat (3) begin
      @(negedge clk_i);
      check("s2_ar_blocked", slv_resp.ar_ready, 0);
      check("s2_ar_mvalid", mst_req.ar_valid, 0);
      check("s2_not_iso", isolated_o, 0);
      tick();
    end
    send_b(4'h2, 2'b01, "s2_b");
    wait_iso(2, "s2_iso");
    check("s2_busy", busy_o, 0);
    check("s2_ar_still_blk", slv_resp.ar_ready, 0);
    tick();

    // Reconnect: pending AR goes through one cycle after leaving ISOLATED.
    isolate = 1'b0;
    @(negedge clk_i);
    check("s5_ar_hold", slv_resp.ar_ready, 0);
    tick();
    @(negedge clk_i);
    check("s5_iso_low", isolated_o, 0);
    check("s5_ar_acc", slv_resp.ar_ready, 1);
    tick();
    slv_req.ar_valid = 1'b0;
    send_r(32'h7777, 1'b1, "s5_r");

    // AW presented with downstream not ready in the same cycle isolation is requested.
    mst_resp.aw_ready = 1'b0;
    slv_req.aw = mk_ax(4'h4, 32'h4000, 8'd0); slv_req.aw_valid = 1'b1; isolate = 1'b1;
    aw_exp.push_back({24'h0, 32'h4000, 8'd0});
    repeat (4) begin
      @(negedge clk_i);
      check("s4_hold", mst_req.aw_valid, 1);
      check("s4_not_iso", isolated_o, 0);
      tick();
    end
    mst_resp.aw_ready = 1'b1;
    @(negedge clk_i);
    check("s4_aw_rdy", slv_resp.aw_ready, 1);
    tick();
    slv_req.aw_valid = 1'b0;
    slv_req.w.data = 32'h4444; slv_req.w.last = 1'b1; slv_req.w_valid = 1'b1;
    w_exp.push_back({27'h0, 32'h4444, 4'hF, 1'b1});
    wait_hs(WC, "s4_w");
    slv_req.w_valid = 1'b0;
    @(negedge clk_i);
    check("s4_drain_busy", busy_o, 1);
    check("s4_drain_iso", isolated_o, 0);
    tick();
    send_b(4'h4, 2'b11, "s4_b");
    wait_iso(2, "s4_iso");
    tick();
    isolate = 1'b0;
    tick();
    tick();

    // Asynchronous reset while a read is outstanding.
    slv_req.ar = mk_ax(4'h8, 32'h8000, 8'd3); slv_req.ar_valid = 1'b1;
    ar_exp.push_back({24'h0, 32'h8000, 8'd3});
    wait_hs(AR, "s6_ar");
    slv_req.ar_valid = 1'b0;
    @(negedge clk_i);
    check("s6_rd_busy", busy_o, 1);
    #1 rst_ni = 1'b0;
    #1;
    check("s6_rst_busy", busy_o, 0);
    check("s6_rst_iso", isolated_o, 0);
    slv_req = '0; mst_resp = '0;
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    reset_checks("rst1");

    // Isolation latency with nothing in flight, then async reset out of ISOLATED.
    isolate = 1'b1;
    @(negedge clk_i); check("lat_c0", isolated_o, 0); tick();
    @(negedge clk_i); check("lat_c1", isolated_o, 0); tick();
    @(negedge clk_i); check("lat_c2", isolated_o, 1);
    #1 rst_ni = 1'b0;
    #1;
    check("rst_iso_async", isolated_o, 0);
    isolate = 1'b0;
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    reset_checks("rst2");

    check("aw_q_empty", aw_exp.size(), 0);
    check("w_q_empty", w_exp.size(), 0);
    check("ar_q_empty", ar_exp.size(), 0);
    check("b_q_empty", b_exp.size(), 0);
    check("r_q_empty", r_exp.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
